// File: rtl/spi_master_arbiter_pkg.sv
// Shared types for the SPI master arbiter: FSM encoding and a width helper.
// Pure declarations; no latency or flow-control behaviour of its own.
package spi_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to 0.
// Purely combinational; the caller decides whether a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one 4-wire SPI master among NUM_REQ requesters, round-robin, with a WAIT timeout.
// Grant in IDLE -> spi_begin next cycle; spi_end -> rsp_valid next cycle; no grant while master busy.
module spi_master_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int TIMEOUT_CLK_NUM = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          spi_begin,
  output logic [DATA_WIDTH-1:0]         spi_master_tx_data,
  input  logic                          spi_end,
  input  logic                          spi_is_busy,
  input  logic                          spi_master_rx_data_valid,
  input  logic [DATA_WIDTH-1:0]         spi_master_rx_data,
  input  logic                          spi_cs_n,
  output logic [NUM_REQ-1:0]            spi_cs_n_vec
);
  import spi_master_arbiter_pkg::*;

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(TIMEOUT_CLK_NUM);

  arb_state_t              state, state_nxt;
  logic [IDX_W-1:0]        owner, rr_ptr;
  logic [CNT_W-1:0]        cnt;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_any;
  logic                    accept;
  logic                    timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign accept   = (state == ST_IDLE) && !spi_is_busy && grant_any;
  assign timeout  = (state == ST_WAIT) && !spi_end && (cnt == CNT_W'(TIMEOUT_CLK_NUM - 1));
  assign rsp_data = rx_word;

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    spi_begin    = 1'b0;
    rsp_valid    = '0;
    rsp_err      = 1'b0;
    spi_cs_n_vec = '1;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          req_ready = grant;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        spi_begin           = 1'b1;
        spi_cs_n_vec[owner] = spi_cs_n;
        state_nxt           = ST_WAIT;
      end
      ST_WAIT: begin
        spi_cs_n_vec[owner] = spi_cs_n;
        if (spi_end || timeout) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        spi_cs_n_vec[owner] = spi_cs_n;
        rsp_valid[owner]    = 1'b1;
        rsp_err             = err;
        state_nxt           = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      owner              <= '0;
      rr_ptr             <= '0;
      cnt                <= '0;
      err                <= 1'b0;
      spi_master_tx_data <= '0;
      rx_word            <= '0;
    end else begin
      state <= state_nxt;
      // Zero throughout START, so in WAIT it equals cycles elapsed since spi_begin.
      cnt   <= (state == ST_IDLE) ? '0 : cnt + 1'b1;
      if (accept) begin
        owner              <= grant_idx;
        spi_master_tx_data <= req_tx_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        rx_word            <= '0;
        err                <= 1'b0;
      end
      if ((state == ST_START || state == ST_WAIT) && spi_master_rx_data_valid)
        rx_word <= spi_master_rx_data;
      if (timeout) begin
        rx_word <= '0;
        err     <= 1'b1;
      end
      if (state == ST_RESP)
        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: combinational grant table plus transfer sequences.
module tb_spi_master_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_tx_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             spi_begin;
  logic [DW-1:0]    spi_master_tx_data;
  logic             spi_end;
  logic             spi_is_busy;
  logic             spi_master_rx_data_valid;
  logic [DW-1:0]    spi_master_rx_data;
  logic             spi_cs_n;
  logic [NR-1:0]    spi_cs_n_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .NUM_REQ         (NR),
    .DATA_WIDTH      (DW),
    .TIMEOUT_CLK_NUM (TO)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid                (req_valid),
    .req_tx_data              (req_tx_data),
    .req_ready                (req_ready),
    .rsp_valid                (rsp_valid),
    .rsp_data                 (rsp_data),
    .rsp_err                  (rsp_err),
    .spi_begin                (spi_begin),
    .spi_master_tx_data       (spi_master_tx_data),
    .spi_end                  (spi_end),
    .spi_is_busy              (spi_is_busy),
    .spi_master_rx_data_valid (spi_master_rx_data_valid),
    .spi_master_rx_data       (spi_master_rx_data),
    .spi_cs_n                 (spi_cs_n),
    .spi_cs_n_vec             (spi_cs_n_vec)
  );

  typedef struct {
    logic [NR-1:0] req;
    logic          busy;
    logic [NR-1:0] exp_ready;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transfer for requester idx; returns at the RESP-cycle sample point.
  task automatic xfer(input int idx, input logic [DW-1:0] txw, input logic [DW-1:0] slave_w,
                      input int lat, input bit drop);
    int waited;
    int extra_begin;
    waited = 0;
    while (req_ready == '0 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check("grant_wait_bound", 32'(waited < 40), 32'd1);
    check("grant_onehot", 32'(req_ready), 32'(1) << idx);
    @(negedge clk);
    spi_is_busy = 1'b1;
    spi_cs_n    = 1'b0;
    if (drop) req_valid[idx] = 1'b0;
    #1;
    check("begin_pulse", 32'(spi_begin), 32'd1);
    check("tx_data", 32'(spi_master_tx_data), 32'(txw));
    check("ready_low_start", 32'(req_ready), 32'd0);
    check("cs_demux", 32'(spi_cs_n_vec), (~(32'(1) << idx)) & 32'hF);
    extra_begin = 0;
    repeat (lat) begin
      @(negedge clk); #1;
      if (spi_begin) extra_begin++;
    end
    @(negedge clk);
    spi_end                  = 1'b1;
    spi_master_rx_data_valid = 1'b1;
    spi_master_rx_data       = slave_w;
    #1;
    if (spi_begin) extra_begin++;
    check("no_early_rsp", 32'(rsp_valid), 32'd0);
    check("single_begin", 32'(extra_begin), 32'd0);
    @(negedge clk);
    spi_end                  = 1'b0;
    spi_master_rx_data_valid = 1'b0;
    spi_master_rx_data       = '0;
    spi_is_busy              = 1'b0;
    spi_cs_n                 = 1'b1;
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
    check("rsp_data", 32'(rsp_data), 32'(slave_w));
    check("rsp_err_ok", 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waited;
    bit  early;

    vecs[0] = '{req: 4'b0000, busy: 1'b0, exp_ready: 4'b0000};
    vecs[1] = '{req: 4'b0001, busy: 1'b0, exp_ready: 4'b0001};
    vecs[2] = '{req: 4'b0100, busy: 1'b0, exp_ready: 4'b0100};
    vecs[3] = '{req: 4'b1100, busy: 1'b0, exp_ready: 4'b0100};
    vecs[4] = '{req: 4'b1010, busy: 1'b0, exp_ready: 4'b0010};
    vecs[5] = '{req: 4'b1111, busy: 1'b0, exp_ready: 4'b0001};
    vecs[6] = '{req: 4'b1111, busy: 1'b1, exp_ready: 4'b0000};
    vecs[7] = '{req: 4'b1000, busy: 1'b0, exp_ready: 4'b1000};

    rst                      = 1'b1;
    req_valid                = '0;
    req_tx_data              = '0;
    spi_end                  = 1'b0;
    spi_is_busy              = 1'b0;
    spi_master_rx_data_valid = 1'b0;
    spi_master_rx_data       = '0;
    spi_cs_n                 = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_begin", 32'(spi_begin), 32'd0);
    check("rst_tx_data", 32'(spi_master_tx_data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_cs_vec", 32'(spi_cs_n_vec), 32'hF);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Combinational grant table from rr_ptr=0; requests withdrawn before the edge
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid   = vecs[i].req;
      spi_is_busy = vecs[i].busy;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      #1;
      req_valid   = '0;
      spi_is_busy = 1'b0;
    end
    @(negedge clk); #1;
    check("dropped_no_begin", 32'(spi_begin), 32'd0);
    check("dropped_cs_idle", 32'(spi_cs_n_vec), 32'hF);

    // Single request from requester 2
    req_tx_data[2*DW +: DW] = 16'h00AB;
    req_valid = 4'b0100;
    #1;
    xfer(2, 16'h00AB, 16'h3C5A, 4, 1'b1);

    // All four held from reset: 0,1,2,3,0
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) req_tx_data[i*DW +: DW] = 16'h1000 + 16'(i);
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    xfer(0, 16'h1000, 16'hA000, 2, 1'b0);
    xfer(1, 16'h1001, 16'hA001, 2, 1'b0);
    xfer(2, 16'h1002, 16'hA002, 2, 1'b0);
    xfer(3, 16'h1003, 16'hA003, 2, 1'b0);
    xfer(0, 16'h1000, 16'hA100, 2, 1'b0);
    req_valid = '0;

    // Move rr_ptr to 2, then 1 and 3 together: 3 wins first
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    xfer(1, 16'h1001, 16'hB001, 1, 1'b1);
    req_valid = 4'b1010;
    xfer(3, 16'h1003, 16'hB003, 2, 1'b1);
    xfer(1, 16'h1001, 16'hB101, 2, 1'b1);

    // Timeout with spi_end never asserted
    @(negedge clk);
    req_tx_data[0 +: DW] = 16'h1234;
    req_valid = 4'b0001;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check("to_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid   = '0;
    spi_is_busy = 1'b1;
    spi_cs_n    = 1'b0;
    #1;
    check("to_begin", 32'(spi_begin), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      spi_master_rx_data_valid = (k == 3);
      spi_master_rx_data       = (k == 3) ? 16'hBEEF : 16'h0000;
      #1;
      if (k < 16 && rsp_valid != '0) early = 1'b1;
    end
    check("to_no_early_rsp", 32'(early), 32'd0);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    spi_is_busy = 1'b0;
    spi_cs_n    = 1'b1;
    req_valid   = 4'b0100;
    #1;
    check("to_back_idle", 32'(req_ready), 32'h4);
    #1;
    req_valid = '0;
    @(negedge clk); #1;
    check("to_dropped_no_begin", 32'(spi_begin), 32'd0);

    // Reset in the middle of WAIT for requester 1
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check("rw_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid   = '0;
    spi_is_busy = 1'b1;
    spi_cs_n    = 1'b0;
    #1;
    check("rw_begin", 32'(spi_begin), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_begin_low", 32'(spi_begin), 32'd0);
    check("rw_tx_data", 32'(spi_master_tx_data), 32'd0);
    check("rw_cs_vec", 32'(spi_cs_n_vec), 32'hF);
    check("rw_rsp_err", 32'(rsp_err), 32'd0);
    check("rw_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    spi_is_busy = 1'b0;
    spi_cs_n    = 1'b1;
    req_valid   = 4'b0011;
    #1;
    check("rw_rsp_quiet", 32'(rsp_valid), 32'd0);
    check("rw_next_grant", 32'(req_ready), 32'h1);
    #1;
    req_valid = '0;

    // Master busy blocks the grant until it falls
    @(negedge clk);
    spi_is_busy = 1'b1;
    req_valid   = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("busy_hold%0d", k), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    spi_is_busy = 1'b0;
    #1;
    check("busy_release_grant", 32'(req_ready), 32'd1);
    xfer(0, 16'h1234, 16'hC3C3, 3, 1'b1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
